adder_bist_checker: RTL and testbench
=====================================

Name: adder_bist_checker

Overview:
- Self-checking response end for the combinational adder blocks. It generates the exhaustive operand stream, drives it into an external adder DUT, samples the DUT's sum/carry after a programmable settle time, and compares against a golden result.
- It reports pass/fail, an error count and the first failing vector.
- It sits beside any WIDTH-bit adder (half adder when WIDTH=1) as synthesizable built-in self-test.

Parameters:
- WIDTH, 1, operand width of the adder under test.
- SETTLE_CYC, 1, idle cycles between driving a vector and sampling the response (0 allowed).
- CNT_W, 4, width of the saturating error counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a test run; sampled only in IDLE.
- op_a  out  WIDTH  operand A to DUT (registered).
- op_b  out  WIDTH  operand B to DUT (registered).
- dut_sum  in  WIDTH  DUT sum output.
- dut_carry  in  1  DUT carry output.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 when the last completed run had zero errors; held until the next accepted start.
- err_count  out  CNT_W  mismatching vectors in the current/last run, saturating at 2^CNT_W-1.
- fail_a  out  WIDTH  op_a of the first failing vector (0 if none).
- fail_b  out  WIDTH  op_b of the first failing vector (0 if none).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; pattern counter 0. Reset asserted mid-run aborts immediately to IDLE with no done pulse.
- Pattern counter: 2*WIDTH bits, {a,b} with a in the MSBs. op_a/op_b are registered from it. Vector order is (0,0),(0,1),...,(max,max).
- Golden result: full = op_a + op_b computed at WIDTH+1 bits. exp_sum = full[WIDTH-1:0]; exp_carry = full[WIDTH].
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 -> APPLY.
  - Clears err_count, pass, fail_a, fail_b and the pattern counter, and loads op_a/op_b = 0.
- APPLY: 1 cycle; ops stable. -> SETTLE if SETTLE_CYC>0, else CHECK.
- SETTLE: counts SETTLE_CYC cycles. -> CHECK.
- CHECK: 1 cycle; samples dut_sum/dut_carry and compares with golden.
  - On mismatch: err_count increments (saturating). If this is the first error, fail_a/fail_b capture op_a/op_b.
  - If the last pattern -> DONE; else increment the pattern, update op_a/op_b, -> APPLY.
- DONE: 1 cycle. done=1 and pass=(err_count==0, including the final CHECK result). busy drops. -> IDLE.
- Timing:
  - Per-vector cost is 2+SETTLE_CYC cycles.
  - With start sampled at edge 0, done is high after edge 1 + 2^(2*WIDTH)*(2+SETTLE_CYC).
- start while not in IDLE is ignored. start held high in IDLE after DONE immediately starts a new run.
- op_a/op_b hold their last vector after DONE until the next start.
- X/Z on dut inputs is treated as whatever the simulator compares. The checker makes no special case.

Decomposition:
- Shared package adder_bist_pkg:
  - state enum (IDLE, APPLY, SETTLE, CHECK, DONE);
  - function golden_add(a,b) returning {carry,sum} at WIDTH+1 bits.
- One sub-module: adder_bist_cmp. It is combinational and compares the DUT response with golden_add, outputting mismatch. It is reusable by other adder checkers.
- FSM, counters and capture registers live in the top.

Test Plan:
- WIDTH=1, SETTLE_CYC=1, correct half-adder model attached; start at edge 0 -> done pulse after edge 13; pass=1; err_count=0; fail_a=fail_b=0.
- Same config, dut_carry tied 0 -> err_count=1; fail_a=1, fail_b=1; pass=0.
- DUT miswired with B driven from A (sum=0, carry=a) -> mismatches on (0,1) and (1,0); err_count=2; fail_a=0, fail_b=1; pass=0.
- WIDTH=2, CNT_W=4, dut_sum inverted -> all 16 vectors fail; err_count saturates at 15; fail_a=0, fail_b=0.
- start pulsed again during CHECK of vector 2 -> ignored, done timing unchanged. rst asserted at cycle 5 -> next cycle all outputs 0, busy=0, no done. New start completes a normal run.
- SETTLE_CYC=0, WIDTH=1 -> done after edge 9; correct DUT gives pass=1.

Source files
------------

// File: rtl/adder_bist_pkg.sv
// Shared types and golden model for the adder BIST checkers.
package adder_bist_pkg;

  // Widest operand golden_add supports; narrower adders zero-extend into it.
  localparam int unsigned GoldenWidth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StCheck,
    StDone
  } state_e;

  // Reference sum: {carry, sum} of two GoldenWidth-bit operands.
  function automatic logic [GoldenWidth:0] golden_add(input logic [GoldenWidth-1:0] a,
                                                      input logic [GoldenWidth-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/adder_bist_cmp.sv
// Combinational compare of an adder response against the golden sum.
module adder_bist_cmp
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_carry,
  output logic             mismatch
);

  logic [GoldenWidth-1:0] a_ext;
  logic [GoldenWidth-1:0] b_ext;
  logic [GoldenWidth:0]   resp_ext;

  // Operands are below 2^WIDTH, so the golden upper bits are zero and the
  // full-width compare is equivalent to comparing {carry, sum} at WIDTH+1 bits.
  always_comb begin
    a_ext    = GoldenWidth'(op_a);
    b_ext    = GoldenWidth'(op_b);
    resp_ext = (GoldenWidth + 1)'({dut_carry, dut_sum});
    mismatch = (golden_add(a_ext, b_ext) != resp_ext);
  end

endmodule

// File: rtl/adder_bist_checker.sv
// Exhaustive BIST driver/checker for a WIDTH-bit combinational adder.
module adder_bist_checker
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int unsigned PatW = 2 * WIDTH;
  localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e           state_q, state_d;
  logic [PatW-1:0]  pat_q, pat_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;
  logic             mismatch;
  logic             last_pat;
  logic             settle_last;

  // Operands come straight from the pattern register, a in the MSBs.
  assign op_a        = pat_q[PatW-1:WIDTH];
  assign op_b        = pat_q[WIDTH-1:0];
  assign last_pat    = (pat_q == {PatW{1'b1}});
  assign settle_last = (settle_q == SetW'(SETTLE_CYC - 1));

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;

  adder_bist_cmp #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .op_a     (op_a),
    .op_b     (op_b),
    .dut_sum  (dut_sum),
    .dut_carry(dut_carry),
    .mismatch (mismatch)
  );

  // Sequencing: IDLE -> (APPLY -> [SETTLE] -> CHECK)* -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StApply;
      StApply:  state_d = (SETTLE_CYC > 0) ? StSettle : StCheck;
      StSettle: if (settle_last) state_d = StCheck;
      StCheck:  state_d = last_pat ? StDone : StApply;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next state: pattern, settle timer, error tally and capture.
  always_comb begin
    pat_d    = pat_q;
    settle_d = '0;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    pass_d   = pass_q;
    // done is registered off DONE so the pulse lands as busy drops.
    done_d   = (state_q == StDone);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pat_d    = '0;
          err_d    = '0;
          fail_a_d = '0;
          fail_b_d = '0;
          pass_d   = 1'b0;
        end
      end
      StSettle: settle_d = settle_q + SetW'(1);
      StCheck: begin
        if (mismatch) begin
          if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
          if (err_q == '0) begin
            fail_a_d = op_a;
            fail_b_d = op_b;
          end
        end
        if (!last_pat) pat_d = pat_q + PatW'(1);
      end
      StDone:  pass_d = (err_q == '0);
      default: ;
    endcase
  end

  // State registers with synchronous reset; reset aborts any run silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pat_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench: three checker configurations, each with a bench-side adder that can
// be made faulty; a timeline model predicts every output every cycle.
module tb_adder_bist_checker;

  localparam int W_CFG [3] = '{1, 1, 2};
  localparam int S_CFG [3] = '{1, 0, 2};
  localparam int C_CFG [3] = '{4, 4, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [2:0] st;
  assign st = {start2, start1, start0};

  logic [0:0] op_a0, op_b0, sum0, fa0, fb0;
  logic [0:0] op_a1, op_b1, sum1, fa1, fb1;
  logic [1:0] op_a2, op_b2, sum2, fa2, fb2;
  logic       carry0, carry1, carry2;
  logic       busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
  logic [3:0] err0, err1, err2;
  logic [1:0] r0, r1;
  logic [2:0] r2;

  // Model / stimulus state.
  int mode [3];
  int corrupt [3][16];
  bit cur_err [3][16];
  bit run_err [3][16];
  bit has_run [3];
  int e0 [3];
  int cyc = 0;
  bit chk_en = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int d0, d1, d2;

  adder_bist_checker #(.WIDTH(1), .SETTLE_CYC(1), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .start(start0), .op_a(op_a0), .op_b(op_b0), .dut_sum(sum0),
    .dut_carry(carry0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_a(fa0), .fail_b(fb0)
  );
  adder_bist_checker #(.WIDTH(1), .SETTLE_CYC(0), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1), .dut_sum(sum1),
    .dut_carry(carry1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_a(fa1), .fail_b(fb1)
  );
  adder_bist_checker #(.WIDTH(2), .SETTLE_CYC(2), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .start(start2), .op_a(op_a2), .op_b(op_b2), .dut_sum(sum2),
    .dut_carry(carry2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_a(fa2), .fail_b(fb2)
  );

  // Adder under test as seen by instance id, in integer {carry,sum} form.
  function automatic int resp(input int id, input int a, input int b);
    int w = W_CFG[id];
    int mask = (1 << w) - 1;
    int full = a + b;
    case (mode[id])
      0:       return full ^ corrupt[id][(a << w) | b];
      1:       return full & mask;   // carry stuck at 0
      2:       return a + a;         // B input miswired to A
      default: return full ^ mask;   // sum inverted
    endcase
  endfunction

  always_comb r0 = 2'(resp(0, int'(op_a0), int'(op_b0)));
  always_comb r1 = 2'(resp(1, int'(op_a1), int'(op_b1)));
  always_comb r2 = 3'(resp(2, int'(op_a2), int'(op_b2)));
  assign {carry0, sum0} = r0;
  assign {carry1, sum1} = r1;
  assign {carry2, sum2} = r2;

  function automatic int t_of(input int id);
    return 1 + (1 << (2 * W_CFG[id])) * (2 + S_CFG[id]);
  endfunction

  task automatic set_mode(input int id, input int md, input int rate);
    int w = W_CFG[id];
    int mask = (1 << w) - 1;
    int n = 1 << (2 * w);
    mode[id] = md;
    for (int v = 0; v < 16; v++) begin
      corrupt[id][v] = 0;
      if (md == 0 && v < n && $urandom_range(0, 99) < rate)
        corrupt[id][v] = $urandom_range(1, (2 << w) - 1);
    end
    for (int v = 0; v < 16; v++)
      cur_err[id][v] = (v < n) && (resp(id, v >> w, v & mask) != (v >> w) + (v & mask));
  endtask

  // Model: record when each instance accepts a start (only while idle).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int id = 0; id < 3; id++) begin
      if (rst) has_run[id] <= 1'b0;
      else if (st[id] && (!has_run[id] || (cyc + 1 - e0[id]) >= t_of(id) + 1)) begin
        has_run[id] <= 1'b1;
        e0[id]      <= cyc + 1;
        for (int v = 0; v < 16; v++) run_err[id][v] <= cur_err[id][v];
      end
    end
  end

  task automatic check(input string name, input int id, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d cycle %0d: got %0d expected %0d", name, id, cyc, act, exp);
    end
  endtask

  task automatic get_act(input int id, output int b, output int d, output int p, output int e,
                         output int fa, output int fb, output int oa, output int ob);
    case (id)
      0: begin
        b = busy0; d = done0; p = pass0; e = int'(err0);
        fa = int'(fa0); fb = int'(fb0); oa = int'(op_a0); ob = int'(op_b0);
      end
      1: begin
        b = busy1; d = done1; p = pass1; e = int'(err1);
        fa = int'(fa1); fb = int'(fb1); oa = int'(op_a1); ob = int'(op_b1);
      end
      default: begin
        b = busy2; d = done2; p = pass2; e = int'(err2);
        fa = int'(fa2); fb = int'(fb2); oa = int'(op_a2); ob = int'(op_b2);
      end
    endcase
  endtask

  // Expected outputs from elapsed cycles since the accepting edge.
  task automatic expect_of(input int id, output int b, output int d, output int p, output int e,
                           output int fa, output int fb, output int oa, output int ob);
    int w = W_CFG[id];
    int mask = (1 << w) - 1;
    int per = 2 + S_CFG[id];
    int n = 1 << (2 * w);
    int t = t_of(id);
    int j, k, m, cnt, total, first;
    b = 0; d = 0; p = 0; e = 0; fa = 0; fb = 0; oa = 0; ob = 0;
    if (has_run[id]) begin
      j = cyc - e0[id];
      k = (j / per > n - 1) ? n - 1 : j / per;
      m = (j / per > n) ? n : j / per;
      cnt = 0; total = 0; first = -1;
      for (int v = 0; v < n; v++) begin
        if (run_err[id][v]) begin
          total++;
          if (v < m) begin
            cnt++;
            if (first < 0) first = v;
          end
        end
      end
      b  = int'(j < t);
      d  = int'(j == t);
      p  = int'(j >= t && total == 0);
      e  = (cnt > (1 << C_CFG[id]) - 1) ? (1 << C_CFG[id]) - 1 : cnt;
      fa = (first < 0) ? 0 : first >> w;
      fb = (first < 0) ? 0 : first & mask;
      oa = k >> w;
      ob = k & mask;
    end
  endtask

  // Compare process: every instance, every cycle, on the falling edge.
  initial begin
    int ab, ad, ap, ae, afa, afb, aoa, aob;
    int xb, xd, xp, xe, xfa, xfb, xoa, xob;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int id = 0; id < 3; id++) begin
          get_act(id, ab, ad, ap, ae, afa, afb, aoa, aob);
          expect_of(id, xb, xd, xp, xe, xfa, xfb, xoa, xob);
          check("busy", id, ab, xb);
          check("done", id, ad, xd);
          check("pass", id, ap, xp);
          check("err_count", id, ae, xe);
          check("fail_a", id, afa, xfa);
          check("fail_b", id, afb, xfb);
          check("op_a", id, aoa, xoa);
          check("op_b", id, aob, xob);
        end
      end
    end
  end

  // Start the selected instances together; report the edge index of done.
  task automatic run_all(input bit s0, input bit s1, input bit s2,
                         output int o0, output int o1, output int o2);
    o0 = -1; o1 = -1; o2 = -1;
    start0 = s0; start1 = s1; start2 = s2;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (s0 && o0 < 0 && done0) o0 = n;
      if (s1 && o1 < 0 && done1) o1 = n;
      if (s2 && o2 < 0 && done2) o2 = n;
      if ((!s0 || o0 >= 0) && (!s1 || o1 >= 0) && (!s2 || o2 >= 0)) break;
      @(negedge clk);
    end
    if (s0) check("done_seen", 0, int'(o0 >= 0), 1);
    if (s1) check("done_seen", 1, int'(o1 >= 0), 1);
    if (s2) check("done_seen", 2, int'(o2 >= 0), 1);
  endtask

  initial begin
    for (int id = 0; id < 3; id++) set_mode(id, 0, 0);
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 0, busy0, 0);
    check("rst_err", 2, int'(err2), 0);
    rst = 1'b0;
    @(negedge clk);

    // Correct adders everywhere.
    run_all(1, 1, 1, d0, d1, d2);
    check("done_edge", 0, d0, 13);
    check("done_edge", 1, d1, 9);
    check("done_edge", 2, d2, 65);
    check("pass_good", 0, pass0, 1);
    check("pass_good", 1, pass1, 1);
    check("err_good", 0, int'(err0), 0);

    // Carry stuck, B miswired from A, sum inverted.
    set_mode(0, 1, 0); set_mode(1, 2, 0); set_mode(2, 3, 0);
    run_all(1, 1, 1, d0, d1, d2);
    check("carry0_err", 0, int'(err0), 1);
    check("carry0_fa", 0, int'(fa0), 1);
    check("carry0_fb", 0, int'(fb0), 1);
    check("carry0_pass", 0, pass0, 0);
    check("miswire_err", 1, int'(err1), 2);
    check("miswire_fa", 1, int'(fa1), 0);
    check("miswire_fb", 1, int'(fb1), 1);
    check("miswire_pass", 1, pass1, 0);
    check("inv_err_sat", 2, int'(err2), 15);
    check("inv_fa", 2, int'(fa2), 0);
    check("inv_fb", 2, int'(fb2), 0);

    // Randomly corrupted responses.
    repeat (6) begin
      for (int id = 0; id < 3; id++) set_mode(id, 0, $urandom_range(0, 60));
      run_all(1, 1, 1, d0, d1, d2);
      check("done_edge_rand", 0, d0, 13);
      check("done_edge_rand", 2, d2, 65);
    end

    // start held high: back-to-back runs, start ignored while busy.
    set_mode(0, 0, 40);
    start0 = 1'b1;
    repeat (40) @(negedge clk);
    start0 = 1'b0;
    repeat (20) @(negedge clk);

    // Extra start during CHECK of vector 2 must not disturb timing.
    set_mode(0, 0, 30);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (8) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    d0 = -1;
    for (int n = 9; n < 60; n++) begin
      if (done0) begin
        d0 = n;
        break;
      end
      @(negedge clk);
    end
    check("done_edge_restart", 0, d0, 13);
    @(negedge clk);

    // Reset at cycle 5 of a failing run.
    set_mode(0, 3, 0); set_mode(2, 3, 0);
    start0 = 1'b1; start2 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start2 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_err", 0, int'(err0), 1);
    check("pre_rst_opb", 0, int'(op_b0), 1);
    check("pre_rst_err", 2, int'(err2), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_busy", 0, busy0, 0);
    check("post_rst_err", 0, int'(err0), 0);
    check("post_rst_opb", 0, int'(op_b0), 0);
    check("post_rst_busy", 2, busy2, 0);
    repeat (15) @(negedge clk);
    set_mode(0, 0, 0); set_mode(2, 0, 0);
    run_all(1, 0, 1, d0, d1, d2);
    check("done_edge_after_rst", 0, d0, 13);
    check("done_edge_after_rst", 2, d2, 65);
    check("pass_after_rst", 0, pass0, 1);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
